mem_port_arbiter: RTL and testbench

//  Shares one 32-bit single-ported memory bus between the instruction fetch unit (64-bit, two-instruction fetch)
//  and the data-access execute unit (32-bit load/store with byte enables). Registered FSM, one outstanding memory

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates one 32-bit memory port between 64-bit fetch and 32-bit data access
// Optional stall counters: define ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [63:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wea,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wea,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
`ifdef ARB_PERF_EN
  output logic [31:0] perf_if_stall,
  output logic [31:0] perf_dm_stall,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, D_REQ, D_RESP, F0_REQ, F0_RESP, F1_REQ, F1_RESP
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_next;
  logic        grant_d, grant_f;
  logic [3:0]  starve;
  logic        drop;
  logic [31:0] fetch_lo;
  logic        in_fetch;
  logic        drop_now;

  assign in_fetch = (state == F0_REQ) || (state == F0_RESP) ||
                    (state == F1_REQ) || (state == F1_RESP);
  // A flush arriving in the same cycle as a response counts as already set.
  assign drop_now = drop || flush;
  assign mem_req  = (state == D_REQ) || (state == F0_REQ) || (state == F1_REQ);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_f    = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !(if_req && starve == LIMIT)) begin
          grant_d    = 1'b1;
          state_next = D_REQ;
        end else if (if_req) begin
          grant_f    = 1'b1;
          state_next = F0_REQ;
        end
      end
      D_REQ:   if (mem_ready)  state_next = mem_we ? IDLE : D_RESP;
      D_RESP:  if (mem_rvalid) state_next = IDLE;
      F0_REQ:  if (mem_ready)  state_next = F0_RESP;
      F0_RESP: if (mem_rvalid) state_next = drop_now ? IDLE : F1_REQ;
      F1_REQ:  if (mem_ready)  state_next = F1_RESP;
      F1_RESP: if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wea   <= '0;
      fetch_lo  <= '0;
      starve    <= '0;
      drop      <= 1'b0;
    end else begin
      if_gnt    <= grant_f;
      dm_gnt    <= grant_d;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;

      if (grant_d) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_we ? dm_wdata : 32'h0;
        mem_wea   <= dm_we ? dm_wea : 4'h0;
        if (if_req && starve != LIMIT) starve <= starve + 4'd1;
      end

      if (grant_f) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr & 32'hFFFF_FFF8;
        mem_wdata <= '0;
        mem_wea   <= '0;
        starve    <= '0;
      end

      if (state == D_RESP && mem_rvalid) begin
        dm_rdata  <= mem_rdata;
        dm_rvalid <= 1'b1;
      end

      if (state == F0_RESP && mem_rvalid) begin
        fetch_lo <= mem_rdata;
        mem_addr <= mem_addr + 32'd4;
      end

      if (state == F1_RESP && mem_rvalid && !drop_now) begin
        if_rdata  <= {mem_rdata, fetch_lo};
        if_rvalid <= 1'b1;
      end

      if (state != IDLE && state_next == IDLE) drop <= 1'b0;
      else if (in_fetch && flush)              drop <= 1'b1;
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_stall <= '0;
      perf_dm_stall <= '0;
    end else begin
      if (if_req && !if_gnt) perf_if_stall <= perf_if_stall + 32'd1;
      if (dm_req && !dm_gnt) perf_dm_stall <= perf_dm_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wea;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic [3:0]  dm_wea = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wea;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
`ifdef ARB_PERF_EN
  logic [31:0] perf_if_stall, perf_dm_stall;
`endif

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wea(dm_wea), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wea(mem_wea), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
`ifdef ARB_PERF_EN
    .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t       exp_bus[$];
  logic [31:0] exp_dm[$];
  logic [63:0] exp_if[$];
  bit          exp_gnt[$];   // 0 = data grant, 1 = fetch grant

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected or bound expired", name);
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    case (a)
      32'h0000_0100: mdata = 32'hDEAD_BEEF;
      32'h0000_2000: mdata = 32'h1111_1111;
      32'h0000_2004: mdata = 32'h2222_2222;
      default:       mdata = {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Memory model: configurable accept wait and read latency, checks every accepted beat.
  int          ready_lat = 0;
  int          rv_lat = 1;
  int          wait_cnt = 0;
  int          rv_cnt = 0;
  logic [31:0] rv_addr = '0;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mdata(rv_addr);
      end
    end
    mem_ready = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= ready_lat) begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
        if (!mem_we) begin
          rv_cnt  = rv_lat;
          rv_addr = mem_addr;
        end
        if (exp_bus.size() == 0) fail_evt("bus_beat_unexpected");
        else check("bus_beat", {mem_we, mem_addr, mem_wdata, mem_wea}, exp_bus.pop_front());
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst) begin
      if (dm_rvalid) begin
        if (exp_dm.size() == 0) fail_evt("dm_rvalid_unexpected");
        else check("dm_rdata", dm_rdata, exp_dm.pop_front());
      end
      if (if_rvalid) begin
        if (exp_if.size() == 0) fail_evt("if_rvalid_unexpected");
        else check("if_rdata", if_rdata, exp_if.pop_front());
      end
      if (dm_gnt || if_gnt) begin
        if (exp_gnt.size() == 0) fail_evt("gnt_unexpected");
        else check("gnt_order", {dm_gnt, if_gnt}, exp_gnt.pop_front() ? 2'b01 : 2'b10);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit fetch, input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      tick();
      if (fetch ? if_gnt : dm_gnt) break;
    end
    if (k == 50) fail_evt(name);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      if (!busy) break;
      tick();
    end
    if (k == 100) fail_evt(name);
  endtask

  task automatic wait_mem_rvalid(input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (mem_rvalid) break;
    end
    if (k == 50) fail_evt(name);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input string name);
    int lat;
    exp_bus.push_back('{1'b0, a, 32'h0, 4'h0});
    exp_dm.push_back(d);
    exp_gnt.push_back(1'b0);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = a;
    wait_gnt(1'b0, {name, "_gnt"});
    dm_req = 1'b0;
    for (lat = 0; lat < 20; lat++) begin
      tick();
      if (dm_rvalid) break;
    end
    check({name, "_latency"}, lat + 1, 2);
    tick();
    check({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int grants;
    #1;
    check("reset_outputs",
          {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_req, busy},
          '0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Load with one-cycle read latency
    ready_lat = 0; rv_lat = 1;
    do_load(32'h100, 32'hDEAD_BEEF, "load");

    // Two-beat fetch
    exp_bus.push_back('{1'b0, 32'h2000, 32'h0, 4'h0});
    exp_bus.push_back('{1'b0, 32'h2004, 32'h0, 4'h0});
    exp_if.push_back(64'h2222_2222_1111_1111);
    exp_gnt.push_back(1'b1);
    if_req = 1'b1; if_addr = 32'h2000;
    wait_gnt(1'b1, "fetch_gnt");
    if_req = 1'b0;
    wait_idle("fetch_done");
    tick();

    // Misaligned fetch address: low bits ignored
    exp_bus.push_back('{1'b0, 32'hFFFF_FFF8, 32'h0, 4'h0});
    exp_bus.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0});
    exp_if.push_back(64'hFFFC_0003_FFF8_0007);
    exp_gnt.push_back(1'b1);
    if_req = 1'b1; if_addr = 32'hFFFF_FFFD;
    wait_gnt(1'b1, "fetch_hi_gnt");
    if_req = 1'b0;
    wait_idle("fetch_hi_done");
    tick();

    // Starvation: both requests held, expect D,D,D,D,F repeating
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        exp_bus.push_back('{1'b1, 32'h80, 32'hCAFE_0000, 4'hF});
        exp_gnt.push_back(1'b0);
      end
      exp_bus.push_back('{1'b0, 32'h3000, 32'h0, 4'h0});
      exp_bus.push_back('{1'b0, 32'h3004, 32'h0, 4'h0});
      exp_gnt.push_back(1'b1);
      exp_if.push_back(64'h3004_CFFB_3000_CFFF);
    end
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hCAFE_0000; dm_wea = 4'hF;
    if_req = 1'b1; if_addr = 32'h3000;
    grants = 0;
    for (int k = 0; k < 300 && grants < 10; k++) begin
      tick();
      if (dm_gnt || if_gnt) grants++;
    end
    dm_req = 1'b0; if_req = 1'b0;
    check("starve_grants", grants, 10);
    wait_idle("starve_done");
    tick();

    // Store with delayed accept: bus must hold steady
    ready_lat = 3;
    exp_bus.push_back('{1'b1, 32'h40, 32'h1234_5678, 4'b0011});
    exp_gnt.push_back(1'b0);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234_5678; dm_wea = 4'b0011;
    wait_gnt(1'b0, "store_gnt");
    dm_req = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_wea = 4'h0;
    for (int i = 0; i < 3; i++) begin
      check("store_hold", {mem_req, mem_we, mem_addr, mem_wdata, mem_wea},
            {1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'b0011});
      tick();
    end
    tick();
    check("store_idle", busy, 1'b0);
    ready_lat = 0;
    tick();

    // Flush during F0_RESP: no second beat, no delivery
    rv_lat = 3;
    exp_bus.push_back('{1'b0, 32'h6000, 32'h0, 4'h0});
    exp_gnt.push_back(1'b1);
    if_req = 1'b1; if_addr = 32'h6000;
    wait_gnt(1'b1, "flush_gnt");
    if_req = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_mem_rvalid("flush_rvalid");
    tick();
    check("flush_idle", busy, 1'b0);
    repeat (6) tick();

    // Reset during F1_RESP, late read data must be ignored
    rv_lat = 4;
    exp_bus.push_back('{1'b0, 32'h5000, 32'h0, 4'h0});
    exp_bus.push_back('{1'b0, 32'h5004, 32'h0, 4'h0});
    exp_gnt.push_back(1'b1);
    if_req = 1'b1; if_addr = 32'h5000;
    wait_gnt(1'b1, "rst_fetch_gnt");
    if_req = 1'b0;
    begin
      int k;
      for (k = 0; k < 60; k++) begin
        tick();
        if (mem_req && mem_addr == 32'h5004) break;
      end
      if (k == 60) fail_evt("rst_f1_beat");
    end
    tick();
    rst = 1'b0;
    #1;
    check("rst_outputs",
          {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wea, busy},
          '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_mem_rvalid("rst_late_rvalid");
    tick();
    check("rst_late_idle", busy, 1'b0);
    tick();

    // Post-reset load with flush held high: flush has no effect on data
    rv_lat = 1;
    flush = 1'b1;
    do_load(32'h100, 32'hDEAD_BEEF, "post_rst_load");
    flush = 1'b0;
    repeat (4) tick();

    check("bus_queue_empty", exp_bus.size(), 0);
    check("dm_queue_empty", exp_dm.size(), 0);
    check("if_queue_empty", exp_if.size(), 0);
    check("gnt_queue_empty", exp_gnt.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
